// File: rtl/bsg_dff_chain_valid_pkg.sv
// Shared helpers for the valid/data register chain: occupancy-counter width sizing.
package bsg_dff_chain_valid_pkg;

  // Bits needed to encode x distinct values, never less than one bit.
  function automatic int safe_clog2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < x) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bsg_dff_chain_valid_stage.sv
// One pipeline slot: a resettable valid bit plus an unreset data register,
// both updating only when the slot is told to advance.
module bsg_dff_chain_valid_stage #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               advance_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic               v_q, v_d;
  logic [width_p-1:0] data_q, data_d;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (advance_i) begin
      v_d = v_i;
      if (v_i) data_d = data_i;
    end
    if (reset_i | clear_i) v_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    v_q    <= v_d;
    data_q <= data_d;
  end

  assign v_o    = v_q;
  assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_chain_valid.sv
// Valid/ready register chain of num_stages_p slots with flush and occupancy count.
// Define BSG_DFF_CHAIN_VALID_BUBBLE_COLLAPSE_EN for bubble-collapsing; default is global stall.
module bsg_dff_chain_valid
  import bsg_dff_chain_valid_pkg::*;
#(
  parameter int width_p      = 16,
  parameter int num_stages_p = 2
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         flush_i,
  input  logic                                         v_i,
  input  logic [width_p-1:0]                           data_i,
  output logic                                         ready_and_o,
  output logic                                         v_o,
  output logic [width_p-1:0]                           data_o,
  input  logic                                         ready_and_i,
  output logic [safe_clog2(num_stages_p+1)-1:0]        count_o
);

  localparam int count_width_lp = safe_clog2(num_stages_p + 1);

  if (num_stages_p == 0) begin : g_pass
    assign v_o         = v_i;
    assign data_o      = data_i;
    assign ready_and_o = ready_and_i;
    assign count_o     = '0;
  end else begin : g_chain
    // Index 0 is the accepted upstream item; index num_stages_p is the output slot.
    logic               valid   [0:num_stages_p];
    logic [width_p-1:0] data    [0:num_stages_p];
    logic               advance [1:num_stages_p];
    logic [count_width_lp-1:0] count_sum;

`ifdef BSG_DFF_CHAIN_VALID_BUBBLE_COLLAPSE_EN
    // A slot may move when it is empty or the slot ahead of it moves.
    always_comb begin
      advance[num_stages_p] = ~valid[num_stages_p] | ready_and_i;
      for (int k = num_stages_p - 1; k >= 1; k--) begin
        advance[k] = ~valid[k] | advance[k+1];
      end
    end
`else
    for (genvar gi = 1; gi <= num_stages_p; gi++) begin : g_adv
      assign advance[gi] = ~v_o | ready_and_i;
    end
`endif

    assign ready_and_o = advance[1] & ~reset_i & ~flush_i;
    assign valid[0]    = v_i & ready_and_o;
    assign data[0]     = data_i;

    for (genvar gi = 1; gi <= num_stages_p; gi++) begin : g_stage
      bsg_dff_chain_valid_stage #(.width_p(width_p)) u_stage (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (flush_i),
        .advance_i (advance[gi]),
        .v_i       (valid[gi-1]),
        .data_i    (data[gi-1]),
        .v_o       (valid[gi]),
        .data_o    (data[gi])
      );
    end

    always_comb begin
      count_sum = '0;
      for (int k = 1; k <= num_stages_p; k++) begin
        count_sum = count_sum + count_width_lp'(valid[k]);
      end
    end

    assign v_o     = valid[num_stages_p];
    assign data_o  = data[num_stages_p];
    assign count_o = count_sum;
  end

endmodule
